// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller: register map,
// FSM encoding and the "no source" ID.
package irq_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADR_W  = 4;
    localparam int unsigned SEL_W  = 4;

    // Register select is wb_adr_i[3:2]
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    localparam int unsigned ID_NONE = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACKD    = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// Wishbone slave bus bundle for the interrupt controller.
interface wb_irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADR_W-1:0]  wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; bit k maps to ID k+1, ID 0 means none.
module irq_prio_enc #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned ID_W    = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id_c,
    output logic               valid_c
);

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        id_c    = '0;
        valid_c = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id_c    = ID_W'(i + 1);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone external interrupt controller: synchronises sources, latches them
// edge/level, and sequences request/ack/claim/complete towards meip_o.
module wb_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned ID_W    = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    wb_irq_ctrl_if.slave       wb,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               irq_ack_i,
    output logic               meip_o
);

    logic [NUM_SRC-1:0] sync1, sync2, dly;
    logic [NUM_SRC-1:0] pending, pending_d, enable, mode, eligible;
    logic [NUM_SRC-1:0] w1c, mode_chg, claim_clr;
    logic [ID_W-1:0]    win_id, in_service;
    logic               win_valid;
    logic [1:0]         reg_sel;
    logic [DATA_W-1:0]  rdata;
    logic               acc, wr, claim_rd, claim_take, complete_ok;
    state_t             state, state_d;
    logic               unused_bits;

    assign reg_sel  = wb.wb_adr_i[3:2];
    assign acc      = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr       = acc & wb.wb_we_i & (wb.wb_sel_i == {SEL_W{1'b1}});
    assign claim_rd = acc & ~wb.wb_we_i & (reg_sel == REG_CLAIM);
    assign eligible = pending & enable;

    assign claim_take  = claim_rd & (state != ST_SERVICE) & win_valid;
    assign complete_ok = wr & (reg_sel == REG_CLAIM) & (state == ST_SERVICE)
                       & (wb.wb_dat_i[ID_W-1:0] == in_service);

    assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i[DATA_W-1:NUM_SRC]};

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .req     (eligible),
        .id_c    (win_id),
        .valid_c (win_valid)
    );

    // Edge bits: set beats clear; level bits track the synced input; MODE change clears
    always_comb begin
        w1c       = '0;
        mode_chg  = '0;
        claim_clr = '0;
        if (wr && reg_sel == REG_PENDING) w1c = wb.wb_dat_i[NUM_SRC-1:0];
        if (wr && reg_sel == REG_MODE)    mode_chg = wb.wb_dat_i[NUM_SRC-1:0] ^ mode;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            claim_clr[k] = claim_take && (win_id == ID_W'(k + 1));
        end
        pending_d = (mode & ((pending & ~(w1c | claim_clr)) | (sync2 & ~dly)))
                  | (~mode & sync2);
        pending_d = pending_d & ~mode_chg;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING: rdata = DATA_W'(pending);
            REG_ENABLE:  rdata = DATA_W'(enable);
            REG_MODE:    rdata = DATA_W'(mode);
            REG_CLAIM:   if (state != ST_SERVICE) rdata = DATA_W'(win_id);
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (claim_rd)       state_d = win_valid ? ST_SERVICE : ST_IDLE;
                else if (win_valid) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (claim_rd)        state_d = win_valid ? ST_SERVICE : ST_IDLE;
                else if (irq_ack_i)  state_d = ST_ACKD;
                else if (!win_valid) state_d = ST_IDLE;
            end
            ST_ACKD: begin
                if (claim_rd) state_d = win_valid ? ST_SERVICE : ST_IDLE;
            end
            ST_SERVICE: begin
                if (complete_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= ST_IDLE;
            meip_o <= 1'b0;
        end else begin
            state  <= state_d;
            meip_o <= (state_d == ST_REQ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1       <= '0;
            sync2       <= '0;
            dly         <= '0;
            pending     <= '0;
            enable      <= '0;
            mode        <= '0;
            in_service  <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            sync1       <= irq_src_i;
            sync2       <= sync1;
            dly         <= sync2;
            pending     <= pending_d;
            wb.wb_ack_o <= acc;
            wb.wb_dat_o <= (acc && !wb.wb_we_i) ? rdata : '0;
            if (wr && reg_sel == REG_ENABLE) enable <= wb.wb_dat_i[NUM_SRC-1:0];
            if (wr && reg_sel == REG_MODE)   mode   <= wb.wb_dat_i[NUM_SRC-1:0];
            if (claim_take)       in_service <= win_id;
            else if (complete_ok) in_service <= ID_W'(ID_NONE);
        end
    end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench for wb_irq_ctrl: read expectations go to a scoreboard queue
// that a negedge monitor drains on every read acknowledge.
module tb_wb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int unsigned NUM_SRC = 16;
    localparam int unsigned ID_W    = 5;
    localparam logic [3:0] A_PEND  = 4'h0;
    localparam logic [3:0] A_EN    = 4'h4;
    localparam logic [3:0] A_MODE  = 4'h8;
    localparam logic [3:0] A_CLAIM = 4'hC;

    logic               clk;
    logic               reset;
    logic               irq_ack;
    logic               meip;
    logic [NUM_SRC-1:0] src;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    wb_irq_ctrl_if bus();

    wb_irq_ctrl #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .wb        (bus.slave),
        .irq_src_i (src),
        .irq_ack_i (irq_ack),
        .meip_o    (meip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Monitor: every read ack pops one expectation
    always @(negedge clk) begin
        string       nm;
        logic [31:0] e;
        if (!reset && bus.wb_ack_o && !bus.wb_we_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_ack", 32'd1, 32'd0);
            end else begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                check(nm, bus.wb_dat_o, e);
            end
        end
    end

    task automatic bus_cycle(input logic we, input logic [3:0] adr,
                             input logic [31:0] d, input logic [3:0] sel);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
    endtask

    task automatic rd(input string name, input logic [3:0] adr, input logic [31:0] exp);
        name_q.push_back(name);
        exp_q.push_back(exp);
        bus_cycle(1'b0, adr, 32'h0, 4'hF);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d);
        bus_cycle(1'b1, adr, d, 4'hF);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_meip(input string name, input logic exp);
        @(negedge clk);
        check(name, 32'(meip), 32'(exp));
    endtask

    task automatic pulse(input int bit_idx);
        @(posedge clk); #1;
        src[bit_idx] = 1'b1;
        @(posedge clk); #1;
        src[bit_idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        irq_ack      = 1'b0;
        src          = '0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 4'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;

        // Reset and idle
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        chk_meip("rst_meip", 1'b0);
        check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        rd("rst_pending", A_PEND, 32'h0);
        rd("rst_enable", A_EN, 32'h0);
        rd("rst_mode", A_MODE, 32'h0);
        rd("rst_claim", A_CLAIM, 32'h0);

        // Edge source full sequence on source 3
        wr(A_EN, 32'h4);
        wr(A_MODE, 32'h4);
        @(posedge clk); #1 src[2] = 1'b1;
        @(posedge clk); #1 src[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_meip("edge_meip_early", 1'b0);
        chk_meip("edge_meip_rise", 1'b1);
        @(posedge clk); #1 irq_ack = 1'b1;
        @(posedge clk); #1 irq_ack = 1'b0;
        chk_meip("edge_ack_drops", 1'b0);
        rd("edge_claim", A_CLAIM, 32'd3);
        rd("edge_pending_cleared", A_PEND, 32'h0);
        wr(A_CLAIM, 32'd3);
        cycles(3);
        chk_meip("edge_after_complete", 1'b0);
        rd("edge_claim_idle", A_CLAIM, 32'h0);

        // Level mode and priority
        wr(A_MODE, 32'h0);
        wr(A_EN, 32'h21);
        src[0] = 1'b1;
        src[5] = 1'b1;
        cycles(5);
        chk_meip("lvl_meip", 1'b1);
        rd("lvl_claim_1", A_CLAIM, 32'd1);
        chk_meip("lvl_service_meip", 1'b0);
        wr(A_CLAIM, 32'd1);
        cycles(3);
        chk_meip("lvl_reassert", 1'b1);
        rd("lvl_claim_1_again", A_CLAIM, 32'd1);
        src[0] = 1'b0;
        cycles(5);
        wr(A_CLAIM, 32'd1);
        rd("lvl_claim_6", A_CLAIM, 32'd6);
        src[5] = 1'b0;
        cycles(5);
        wr(A_CLAIM, 32'd6);
        cycles(3);
        chk_meip("lvl_done", 1'b0);
        rd("lvl_pending_zero", A_PEND, 32'h0);

        // Masking race on source 4
        wr(A_EN, 32'h8);
        src[3] = 1'b1;
        cycles(5);
        chk_meip("mask_req", 1'b1);
        wr(A_EN, 32'h0);
        cycles(2);
        chk_meip("mask_meip_fall", 1'b0);
        rd("mask_claim_zero", A_CLAIM, 32'h0);
        rd("mask_pending_level", A_PEND, 32'h8);
        src[3] = 1'b0;
        cycles(4);

        // Complete mismatch and SERVICE hold
        wr(A_MODE, 32'h82);
        wr(A_EN, 32'h82);
        pulse(1);
        cycles(5);
        chk_meip("svc_req", 1'b1);
        rd("svc_claim_2", A_CLAIM, 32'd2);
        wr(A_CLAIM, 32'd5);
        rd("svc_claim_in_service", A_CLAIM, 32'h0);
        pulse(7);
        cycles(6);
        chk_meip("svc_hold_meip", 1'b0);
        rd("svc_pending_src8", A_PEND, 32'h80);
        wr(A_CLAIM, 32'd2);
        cycles(3);
        chk_meip("svc_reeval", 1'b1);
        rd("svc_claim_8", A_CLAIM, 32'd8);
        wr(A_CLAIM, 32'd8);
        cycles(3);
        chk_meip("svc_done", 1'b0);

        // W1C on an edge bit while requesting
        pulse(7);
        cycles(5);
        chk_meip("w1c_req", 1'b1);
        wr(A_PEND, 32'hFFFF);
        cycles(2);
        chk_meip("w1c_meip_fall", 1'b0);
        rd("w1c_pending", A_PEND, 32'h0);

        // Partial write ignored
        bus_cycle(1'b1, A_EN, 32'hFF, 4'b0011);
        rd("partial_enable", A_EN, 32'h82);

        // Reset during a pending write
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = A_EN;
        bus.wb_dat_i = 32'hFFFF;
        bus.wb_sel_i = 4'hF;
        reset        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_no_ack", 32'(bus.wb_ack_o), 32'd0);
        #1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        rd("rst_mid_enable", A_EN, 32'h0);
        rd("rst_mid_mode", A_MODE, 32'h0);
        chk_meip("rst_mid_meip", 1'b0);

        cycles(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- Wishbone-slave external interrupt controller that drives the core's machine external interrupt line `meip_o`.
- Collects `NUM_SRC` peripheral interrupt sources. Each source is latched as edge-triggered or level-sensitive and is masked by an enable register.
- Claim/complete sequencing ensures only one source is in service at a time; the core's `irq_ack` handshake drops `meip_o`.
- Sits on the SoC Wishbone bus beside memory and replaces the hand-driven `meip_i`/`irq_ack_o` loop of the bench.

Parameters:
- NUM_SRC, 16, number of interrupt sources (1..31); source IDs are 1..NUM_SRC, and ID 0 means "none".
- ID_W, 5, width of the claim/complete ID field; must satisfy 2^ID_W > NUM_SRC.

Ports:
- clk_i  in  1  system clock; single clock domain.
- reset_i  in  1  reset; synchronous, active-high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  4  byte offset; bits [3:2] select the register, bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; a write requires all four set, otherwise it is acked and ignored.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_ack_o  out  1  one-cycle registered acknowledge.
- irq_src_i  in  NUM_SRC  asynchronous interrupt sources; bit k is source ID k+1.
- irq_ack_i  in  1  interrupt acknowledge from the core (its irq_ack_o).
- meip_o  out  1  machine external interrupt pending, to the core's meip_i.

Behaviour:
- Reset: every register, sync flop, PENDING, ENABLE, MODE, in-service ID, wb_ack_o, wb_dat_o and meip_o clears to 0; FSM goes to IDLE. Reset asserted mid-bus-cycle drops the ack and suppresses the write.
- Sources: 2-flop synchronizer per bit, followed by a delay flop for edge detection.
  - MODE[k]=1 (edge): PENDING[k] sets on a rising edge of the synced signal and stays set until claimed or W1C-cleared. If set and clear occur in the same cycle, set wins.
  - MODE[k]=0 (level): PENDING[k] is a registered copy of the synced level. Claim and W1C have no effect on it.
- Eligible = PENDING & ENABLE. Winner = lowest-index eligible bit, which has the highest priority.
- Register map (32-bit, unused bits read 0):
  - 0x0 PENDING: read. Write 1 clears edge-mode bits.
  - 0x4 ENABLE: read/write.
  - 0x8 MODE: read/write. Changing a bit clears PENDING for that bit.
  - 0xC CLAIM: a read returns the winner ID. A write is a complete with ID in bits [ID_W-1:0].
- Wishbone timing:
  - wb_ack_o rises on the cycle after `cyc & stb & !ack` and lasts exactly one cycle.
  - Back-to-back accesses give an ack every other cycle.
  - Register side effects (write, claim) take place on the ack cycle edge.
- FSM states: IDLE, REQ, ACKD, SERVICE. `meip_o` = (state == REQ), registered.
  - IDLE -> REQ when any eligible bit is set.
  - REQ -> ACKD on irq_ack_i.
  - REQ -> IDLE if eligible becomes all-zero before irq_ack_i arrives (source disabled).
  - ACKD holds with meip_o=0 and waits for a CLAIM read.
- CLAIM read in IDLE, REQ or ACKD:
  - With a winner present: returns its ID, latches it as the in-service ID, clears its PENDING bit if edge-mode, and moves to SERVICE.
  - With no winner: returns 0 and moves to IDLE.
- CLAIM read in SERVICE returns 0 and has no side effect.
- Complete write in SERVICE with ID equal to the in-service ID moves to IDLE and clears the in-service ID. A mismatched ID, or a complete written in any other state, is ignored.
- While in SERVICE, meip_o stays 0 even if new sources pend. After complete, IDLE re-evaluates on the next cycle.
- Latency: a source held high from before edge 0 sets PENDING at edge 2 and FSM REQ at edge 3, so meip_o is high after edge 3. This applies to both modes.
- irq_ack_i seen in any state other than REQ is ignored.

Decomposition:
- Package `irq_ctrl_pkg` holds:
  - register offset constants (PENDING, ENABLE, MODE, CLAIM);
  - FSM state encoding (2-bit);
  - the ID 0 "none" constant.
- One sub-module, `irq_prio_enc`: combinational lowest-index priority encoder. Input NUM_SRC bits; outputs ID_W-bit ID (0 if no bit set) and a valid flag.

Test Plan:
- Reset and idle: hold reset_i=1 for 4 cycles, then release. All four registers read 0x0, meip_o=0, and a CLAIM read returns 0.
- Edge source, full sequence: write ENABLE=0x0000_0004 and MODE=0x0000_0004, pulse irq_src_i[2] for 1 cycle.
  - meip_o rises 3 edges after the pulse; irq_ack_i for 1 cycle drops it.
  - CLAIM returns 3 and PENDING reads 0.
  - Writing 3 to CLAIM returns the FSM to IDLE with meip_o staying 0.
- Priority and level: with level mode, set ENABLE=0x0000_0021 and hold irq_src_i[0] and irq_src_i[5] high.
  - Claim returns 1. Complete 1 while src[0] is still high gives meip_o high again, and the next claim returns 1 again.
  - Drop src[0], then complete: the next claim returns 6.
- Masking race: in REQ for source 4, write ENABLE=0 before irq_ack_i. meip_o falls, the FSM goes to IDLE, and a later CLAIM read returns 0.
- Complete mismatch and SERVICE hold: claim ID 2, write complete 5. The state stays SERVICE, a second CLAIM read returns 0, and a new edge on src[7] keeps meip_o=0 until complete 2 is written.
- Partial write and reset mid-cycle: a write with wb_sel_i=4'b0011 to ENABLE is acked and leaves ENABLE unchanged. Asserting reset_i during a pending write gives no ack and ENABLE stays 0.
